// File: rtl/hiscore_ram_arb_if.sv
// hiscore_ram_arb_if: CPU, hiscore-engine and work-RAM signal bundle.
// slave = arbiter side, master = surrounding top level.
interface hiscore_ram_arb_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_din;
  logic              cpu_idle;
  logic              cpu_pause;
  logic              hs_req;
  logic [ADDR_W-1:0] hs_addr;
  logic [DATA_W-1:0] hs_dout;
  logic              hs_we;
  logic              hs_grant;
  logic [DATA_W-1:0] hs_din;
  logic              hs_timeout;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  cpu_addr, cpu_dout, cpu_we, cpu_idle,
    output cpu_din, cpu_pause,
    input  hs_req, hs_addr, hs_dout, hs_we,
    output hs_grant, hs_din, hs_timeout,
    output ram_addr, ram_din, ram_we,
    input  ram_dout
  );

  modport master (
    output cpu_addr, cpu_dout, cpu_we, cpu_idle,
    input  cpu_din, cpu_pause,
    output hs_req, hs_addr, hs_dout, hs_we,
    input  hs_grant, hs_din, hs_timeout,
    input  ram_addr, ram_din, ram_we,
    output ram_dout
  );
endinterface

// File: rtl/hiscore_ram_arb.sv
// hiscore_ram_arb: pauses the CPU and lends the work RAM port to the hiscore engine.
// Optional grant timeout: define HISCORE_ARB_TIMEOUT_EN.
module hiscore_ram_arb #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int SETTLE   = 4,
  parameter int MAX_HOLD = 255
) (
  input logic clk,
  input logic reset,
  hiscore_ram_arb_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE,
    S_SETTLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t            state;
  logic [3:0]        settle_cnt;
  logic              pause;
  logic              grant;
  logic              hs_own;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
`ifdef HISCORE_ARB_TIMEOUT_EN
  logic [7:0]        hold_cnt;
  logic              blocked;
  logic              timeout;
`else
  logic [7:0]        unused_hold;
  assign unused_hold = 8'(MAX_HOLD);
`endif

  // Arbitration FSM; pause/grant/timeout are registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      settle_cnt <= 4'd0;
      pause      <= 1'b0;
      grant      <= 1'b0;
`ifdef HISCORE_ARB_TIMEOUT_EN
      hold_cnt   <= 8'd0;
      blocked    <= 1'b0;
      timeout    <= 1'b0;
`endif
    end else begin
`ifdef HISCORE_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
`ifdef HISCORE_ARB_TIMEOUT_EN
          if (!bus.hs_req) blocked <= 1'b0;
          if (bus.hs_req && !blocked) begin
`else
          if (bus.hs_req) begin
`endif
            state <= S_PAUSE;
            pause <= 1'b1;
          end
        end
        S_PAUSE: begin
          if (!bus.hs_req) begin
            state <= S_RELEASE;
          end else if (bus.cpu_idle) begin
            state      <= S_SETTLE;
            settle_cnt <= 4'(SETTLE - 1);
          end
        end
        S_SETTLE: begin
          if (!bus.hs_req) begin
            state <= S_RELEASE;
          end else if (settle_cnt == 4'd0) begin
            state <= S_GRANT;
            grant <= 1'b1;
`ifdef HISCORE_ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        S_GRANT: begin
          if (!bus.hs_req) begin
            state <= S_RELEASE;
            grant <= 1'b0;
          end
`ifdef HISCORE_ARB_TIMEOUT_EN
          else if (hold_cnt >= 8'(MAX_HOLD - 1)) begin
            state    <= S_RELEASE;
            grant    <= 1'b0;
            timeout  <= 1'b1;
            blocked  <= 1'b1;
            hold_cnt <= 8'(MAX_HOLD);
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
`endif
        end
        S_RELEASE: begin
          state <= S_IDLE;
          pause <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          pause <= 1'b0;
          grant <= 1'b0;
        end
      endcase
    end
  end

  // Reset hands the port back to the CPU in the same cycle
  assign hs_own = grant & ~reset;

  // Port mux: only the owner's strobe can reach the RAM
  always_comb begin
    addr  = bus.cpu_addr;
    wdata = bus.cpu_dout;
    we    = bus.cpu_we;
    if (hs_own) begin
      addr  = bus.hs_addr;
      wdata = bus.hs_dout;
      we    = bus.hs_we;
    end
  end

  assign bus.ram_addr  = addr;
  assign bus.ram_din   = wdata;
  assign bus.ram_we    = we;
  assign bus.cpu_din   = bus.ram_dout;
  assign bus.hs_din    = bus.ram_dout;
  assign bus.cpu_pause = pause;
  assign bus.hs_grant  = grant;
`ifdef HISCORE_ARB_TIMEOUT_EN
  assign bus.hs_timeout = timeout;
`else
  assign bus.hs_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_hiscore_ram_arb.sv
// tb_hiscore_ram_arb: directed and randomized checks of hiscore_ram_arb.
// Reference model: grant/pause/timeout windows from edge arithmetic plus a RAM array.
module tb_hiscore_ram_arb;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int ST = 4;
  localparam int MH = 8;
  localparam int G0 = 2 + ST;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt = 0;
  int   total = 0;

  always #5 clk = ~clk;

  hiscore_ram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  hiscore_ram_arb #(
    .ADDR_W(AW), .DATA_W(DW), .SETTLE(ST), .MAX_HOLD(MH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Synchronous work RAM, one-cycle read latency
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  logic [DW-1:0] ref_mem [16];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.cpu_addr = '0;
    bus.cpu_dout = '0;
    bus.cpu_we   = 1'b0;
    bus.cpu_idle = 1'b0;
    bus.hs_req   = 1'b0;
    bus.hs_addr  = '0;
    bus.hs_dout  = '0;
    bus.hs_we    = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 10'h155;
    bus.cpu_dout = 8'hA5;
    tick();
    tick();
    total++;
    if (bus.ram_we !== 1'b1 || bus.ram_addr !== 10'h155 || bus.ram_din !== 8'hA5)
      $display("FAIL reset_mux: we=%b addr=%h din=%h want 1 155 a5",
               bus.ram_we, bus.ram_addr, bus.ram_din);
    else pass_cnt++;
    total++;
    if (bus.cpu_pause !== 1'b0 || bus.hs_grant !== 1'b0 || bus.hs_timeout !== 1'b0)
      $display("FAIL reset_outs: pause=%b grant=%b to=%b want 0 0 0",
               bus.cpu_pause, bus.hs_grant, bus.hs_timeout);
    else pass_cnt++;
    reset = 1'b0;
    bus.cpu_we = 1'b0;
    tick();
  endtask

  task automatic test_grant_latency;
    bus.cpu_idle = 1'b1;
    bus.hs_req   = 1'b1;
    for (int e = 1; e <= G0; e++) begin
      tick();
      total++;
      if (bus.cpu_pause !== 1'b1 || bus.hs_grant !== (e == G0))
        $display("FAIL latency edge %0d: pause=%b grant=%b want 1 %b",
                 e, bus.cpu_pause, bus.hs_grant, e == G0);
      else pass_cnt++;
    end
    bus.hs_we    = 1'b1;
    bus.hs_addr  = 10'h00B;
    bus.hs_dout  = 8'h10;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 10'h00B;
    bus.cpu_dout = 8'hEE;
    #1;
    total++;
    if (bus.ram_we !== 1'b1 || bus.ram_addr !== 10'h00B || bus.ram_din !== 8'h10)
      $display("FAIL hs_mux: we=%b addr=%h din=%h want 1 00b 10",
               bus.ram_we, bus.ram_addr, bus.ram_din);
    else pass_cnt++;
    tick();
    total++;
    if (mem[10'h00B] !== 8'h10)
      $display("FAIL hs_write: mem=%h want 10", mem[10'h00B]);
    else pass_cnt++;
    bus.hs_we  = 1'b0;
    bus.cpu_we = 1'b0;
    tick();
    total++;
    if (bus.hs_din !== 8'h10 || bus.cpu_din !== 8'h10)
      $display("FAIL hs_read: hs_din=%h cpu_din=%h want 10", bus.hs_din, bus.cpu_din);
    else pass_cnt++;
    bus.hs_req = 1'b0;
    tick();
    total++;
    if (bus.hs_grant !== 1'b0 || bus.cpu_pause !== 1'b1)
      $display("FAIL drop_grant: grant=%b pause=%b want 0 1", bus.hs_grant, bus.cpu_pause);
    else pass_cnt++;
    tick();
    total++;
    if (bus.cpu_pause !== 1'b0)
      $display("FAIL drop_pause: pause=%b want 0", bus.cpu_pause);
    else pass_cnt++;
    bus.cpu_idle = 1'b0;
  endtask

  task automatic test_idle_wait;
    bus.cpu_idle = 1'b0;
    bus.hs_req   = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      total++;
      if (bus.hs_grant !== 1'b0 || bus.cpu_pause !== 1'b1)
        $display("FAIL busy_wait edge %0d: grant=%b pause=%b want 0 1",
                 e, bus.hs_grant, bus.cpu_pause);
      else pass_cnt++;
    end
    bus.cpu_idle = 1'b1;
    for (int e = 1; e <= ST + 1; e++) begin
      tick();
      total++;
      if (bus.hs_grant !== (e == ST + 1))
        $display("FAIL idle_grant edge %0d: grant=%b want %b",
                 e, bus.hs_grant, e == ST + 1);
      else pass_cnt++;
    end
    bus.hs_req = 1'b0;
    tick();
    tick();
    bus.cpu_idle = 1'b0;
    total++;
    if (bus.cpu_pause !== 1'b0 || bus.hs_grant !== 1'b0)
      $display("FAIL idle_release: pause=%b grant=%b want 0 0", bus.cpu_pause, bus.hs_grant);
    else pass_cnt++;
  endtask

  task automatic test_drop_settle;
    bus.cpu_idle = 1'b1;
    bus.hs_req   = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      if (e == 4) bus.hs_req = 1'b0;
      tick();
      total++;
      if (bus.hs_grant !== 1'b0 || bus.cpu_pause !== (e <= 4))
        $display("FAIL settle_drop edge %0d: grant=%b pause=%b want 0 %b",
                 e, bus.hs_grant, bus.cpu_pause, e <= 4);
      else pass_cnt++;
    end
    bus.cpu_idle = 1'b0;
  endtask

  task automatic test_timeout;
    bus.cpu_idle = 1'b1;
    bus.hs_req   = 1'b1;
`ifdef HISCORE_ARB_TIMEOUT_EN
    for (int e = 1; e <= G0 + MH + 10; e++) begin
      tick();
      total++;
      if (bus.hs_grant !== (e >= G0 && e < G0 + MH) ||
          bus.hs_timeout !== (e == G0 + MH) ||
          bus.cpu_pause !== (e <= G0 + MH))
        $display("FAIL timeout edge %0d: grant=%b to=%b pause=%b", e,
                 bus.hs_grant, bus.hs_timeout, bus.cpu_pause);
      else pass_cnt++;
    end
    bus.hs_req = 1'b0;
    tick();
    bus.hs_req = 1'b1;
    for (int e = 1; e <= G0; e++) begin
      tick();
      total++;
      if (bus.hs_grant !== (e == G0) || bus.hs_timeout !== 1'b0)
        $display("FAIL regrant edge %0d: grant=%b to=%b want %b 0",
                 e, bus.hs_grant, bus.hs_timeout, e == G0);
      else pass_cnt++;
    end
`else
    for (int e = 1; e <= 300; e++) begin
      tick();
      total++;
      if (bus.hs_grant !== (e >= G0) || bus.hs_timeout !== 1'b0)
        $display("FAIL long_hold edge %0d: grant=%b to=%b want %b 0",
                 e, bus.hs_grant, bus.hs_timeout, e >= G0);
      else pass_cnt++;
    end
`endif
    bus.hs_req = 1'b0;
    tick();
    tick();
    tick();
    bus.cpu_idle = 1'b0;
  endtask

  task automatic test_reset_mid_grant;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 10'h3F0;
    bus.cpu_dout = 8'h00;
    tick();
    bus.cpu_we   = 1'b0;
    bus.cpu_idle = 1'b1;
    bus.hs_req   = 1'b1;
    for (int e = 1; e <= G0; e++) tick();
    total++;
    if (bus.hs_grant !== 1'b1)
      $display("FAIL rst_pre_grant: grant=%b want 1", bus.hs_grant);
    else pass_cnt++;
    bus.hs_we   = 1'b1;
    bus.hs_addr = 10'h3F0;
    bus.hs_dout = 8'h77;
    reset       = 1'b1;
    #1;
    total++;
    if (bus.ram_we !== bus.cpu_we || bus.ram_addr !== 10'h3F0 || bus.ram_din !== 8'h00)
      $display("FAIL rst_mux: we=%b addr=%h din=%h want 0 3f0 00",
               bus.ram_we, bus.ram_addr, bus.ram_din);
    else pass_cnt++;
    tick();
    total++;
    if (bus.hs_grant !== 1'b0 || bus.cpu_pause !== 1'b0 || bus.ram_we !== 1'b0)
      $display("FAIL rst_grant: grant=%b pause=%b we=%b want 0 0 0",
               bus.hs_grant, bus.cpu_pause, bus.ram_we);
    else pass_cnt++;
    total++;
    if (mem[10'h3F0] !== 8'h00)
      $display("FAIL rst_drop_write: mem=%h want 00", mem[10'h3F0]);
    else pass_cnt++;
    reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_random;
    int d, g, t, r, rel, last;
    bit to, own, rd_valid, w;
    logic [AW-1:0] a;
    logic [DW-1:0] dd, exp_rd;
    for (int i = 0; i < 16; i++) begin
      bus.cpu_we   = 1'b1;
      bus.cpu_addr = AW'(i);
      bus.cpu_dout = DW'($urandom);
      ref_mem[i]   = bus.cpu_dout;
      tick();
    end
    bus.cpu_we = 1'b0;
    rd_valid = 1'b0;
    exp_rd = '0;
    for (int n = 0; n < 25; n++) begin
      d = $urandom_range(0, 5);
      g = 2 + d + ST;
`ifdef HISCORE_ARB_TIMEOUT_EN
      t = g + MH;
      r = $urandom_range(2, g + MH + 4);
`else
      t = 1 << 20;
      r = $urandom_range(2, g + 12);
`endif
      rel  = (r < t) ? r : t;
      to   = (t < r);
      last = ((rel > r) ? rel : r) + 2;
      for (int e = 1; e <= last; e++) begin
        own = (e - 1 >= g) && (e - 1 < rel);
        bus.hs_req   = (e < r);
        bus.cpu_idle = (e >= 2 + d);
        bus.cpu_addr = AW'($urandom_range(0, 15));
        bus.cpu_dout = DW'($urandom);
        bus.cpu_we   = $urandom_range(0, 1) == 1;
        bus.hs_addr  = AW'($urandom_range(0, 15));
        bus.hs_dout  = DW'($urandom);
        bus.hs_we    = $urandom_range(0, 1) == 1;
        a  = own ? bus.hs_addr : bus.cpu_addr;
        dd = own ? bus.hs_dout : bus.cpu_dout;
        w  = own ? bus.hs_we : bus.cpu_we;
        #1;
        total++;
        if (bus.ram_we !== w || bus.ram_addr !== a || bus.ram_din !== dd)
          $display("FAIL rand_mux n%0d e%0d: we=%b addr=%h din=%h want %b %h %h",
                   n, e, bus.ram_we, bus.ram_addr, bus.ram_din, w, a, dd);
        else pass_cnt++;
        if (rd_valid) begin
          total++;
          if (bus.cpu_din !== exp_rd || bus.hs_din !== exp_rd)
            $display("FAIL rand_read n%0d e%0d: cpu=%h hs=%h want %h",
                     n, e, bus.cpu_din, bus.hs_din, exp_rd);
          else pass_cnt++;
        end
        tick();
        exp_rd   = ref_mem[a[3:0]];
        rd_valid = 1'b1;
        if (w) ref_mem[a[3:0]] = dd;
        total++;
        if (bus.hs_grant !== (e >= g && e < rel) ||
            bus.cpu_pause !== (e <= rel) ||
            bus.hs_timeout !== (to && e == t))
          $display("FAIL rand_fsm n%0d e%0d: grant=%b pause=%b to=%b (g=%0d rel=%0d)",
                   n, e, bus.hs_grant, bus.cpu_pause, bus.hs_timeout, g, rel);
        else pass_cnt++;
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_grant_latency();
    test_idle_wait();
    test_drop_settle();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
